// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter plus fixed-timing access sequencer that shares one async SRAM
// between the CPU and the FPGA-logic requesters.
module mem_bus_arbiter #(
  parameter int ADDR_W        = 17,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              fpga_req,
  input  logic              fpga_we,
  input  logic [ADDR_W-1:0] fpga_addr,
  input  logic [DATA_W-1:0] fpga_wdata,
  output logic [DATA_W-1:0] fpga_rdata,
  output logic              fpga_ack,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD   = 4'(ACCESS_CYCLES - 1);
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CPU  = 2'b01;
  localparam logic [1:0] GRANT_FPGA = 2'b10;

  state_t              state;
  logic [3:0]          cnt;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                dq_oe;
  logic                last_fpga;
  logic                mask_cpu;
  logic                mask_fpga;

  logic                cpu_elig;
  logic                fpga_elig;
  logic                pick_fpga;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // The port acked in the previous DONE is ignored for one IDLE cycle, which
  // absorbs a requester whose registered req falls one cycle after its ack.
  always_comb begin
    // NOTE: every output of this block is assigned on every pass, so no latch can be inferred.
    cpu_elig  = cpu_req  & ~mask_cpu;
    fpga_elig = fpga_req & ~mask_fpga;
    pick_fpga = fpga_elig & (~cpu_elig | ~last_fpga);
    sel_we    = pick_fpga ? fpga_we    : cpu_we;
    sel_addr  = pick_fpga ? fpga_addr  : cpu_addr;
    sel_wdata = pick_fpga ? fpga_wdata : cpu_wdata;
  end

  assign sram_dq = dq_oe ? wdata_q : {DATA_W{1'bz}};

  // Strobes are registered, so each transition edge sets them for the state being entered.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      dq_oe      <= 1'b0;
      sram_addr  <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      cpu_ack    <= 1'b0;
      fpga_ack   <= 1'b0;
      cpu_rdata  <= '0;
      fpga_rdata <= '0;
      grant      <= GRANT_NONE;
      busy       <= 1'b0;
      last_fpga  <= 1'b1;
      mask_cpu   <= 1'b0;
      mask_fpga  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
      cpu_ack   <= 1'b0;
      fpga_ack  <= 1'b0;
      mask_cpu  <= 1'b0;
      mask_fpga <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (cpu_elig || fpga_elig) begin
            state     <= S_SETUP;
            busy      <= 1'b1;
            grant     <= pick_fpga ? GRANT_FPGA : GRANT_CPU;
            we_q      <= sel_we;
            wdata_q   <= sel_wdata;
            sram_addr <= sel_addr;
            cnt       <= CNT_LOAD;
            sram_ce_n <= 1'b0;
            if (sel_we) begin
              dq_oe <= 1'b1;
            end else begin
              sram_oe_n <= 1'b0;
            end
          end
        end

        S_SETUP: begin
          state <= S_ACCESS;
          if (we_q) begin
            sram_we_n <= 1'b0;
          end
        end

        S_ACCESS: begin
          if (cnt == 4'd0) begin
            state     <= S_DONE;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            cpu_ack   <= grant[0];
            fpga_ack  <= grant[1];
            if (!we_q) begin
              if (grant[1]) begin
                fpga_rdata <= sram_dq;
              end else begin
                cpu_rdata <= sram_dq;
              end
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_DONE: begin
          // Write data and address are held through DONE for SRAM hold time.
          state     <= S_IDLE;
          busy      <= 1'b0;
          grant     <= GRANT_NONE;
          dq_oe     <= 1'b0;
          last_fpga <= grant[1];
          mask_cpu  <= grant[0];
          mask_fpga <= grant[1];
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: behavioural SRAM, transaction-level
// reference memory, per-transaction strobe accounting and round-robin rules.
module tb_mem_bus_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int AC     = 2;
  localparam int DONE_N = AC + 2;

  logic              sysclk = 1'b0;
  logic              rst_n  = 1'b0;
  logic [1:0]        req;
  logic [1:0]        we_in;
  logic [ADDR_W-1:0] addr_in  [2];
  logic [DATA_W-1:0] wdata_in [2];

  logic [DATA_W-1:0] cpu_rdata, fpga_rdata;
  logic              cpu_ack, fpga_ack;
  logic [ADDR_W-1:0] sram_addr;
  wire  [DATA_W-1:0] sram_dq;
  logic              sram_ce_n, sram_oe_n, sram_we_n;
  logic              busy;
  logic [1:0]        grant;

  mem_bus_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .ACCESS_CYCLES (AC)
  ) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .cpu_req    (req[0]),
    .cpu_we     (we_in[0]),
    .cpu_addr   (addr_in[0]),
    .cpu_wdata  (wdata_in[0]),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .fpga_req   (req[1]),
    .fpga_we    (we_in[1]),
    .fpga_addr  (addr_in[1]),
    .fpga_wdata (wdata_in[1]),
    .fpga_rdata (fpga_rdata),
    .fpga_ack   (fpga_ack),
    .sram_addr  (sram_addr),
    .sram_dq    (sram_dq),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .busy       (busy),
    .grant      (grant)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Unwritten locations read back as a fixed function of the address.
  function automatic logic [DATA_W-1:0] init_byte(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h4A;
  endfunction

  // Behavioural async SRAM on the pins.
  logic [DATA_W-1:0] sram_mem [int];
  logic [DATA_W-1:0] sram_rd;

  function automatic logic [DATA_W-1:0] sram_read(input logic [ADDR_W-1:0] a);
    if (sram_mem.exists(int'(a))) return sram_mem[int'(a)];
    return init_byte(a);
  endfunction

  always @(sram_addr or sram_ce_n or sram_oe_n) sram_rd = sram_read(sram_addr);
  assign sram_dq = (!sram_ce_n && !sram_oe_n) ? sram_rd : {DATA_W{1'bz}};
  always @(posedge sysclk) if (!sram_ce_n && !sram_we_n) sram_mem[int'(sram_addr)] = sram_dq;

  // Transaction-level reference memory, updated in service order.
  logic [DATA_W-1:0] ref_mem [int];

  function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_byte(a);
  endfunction

  logic [1:0]        pend;
  logic [1:0]        pend_snap;
  logic [1:0]        cur_we;
  logic [ADDR_W-1:0] cur_addr  [2];
  logic [DATA_W-1:0] cur_wdata [2];
  logic [DATA_W-1:0] exp_rd    [2];
  int                n;
  int                gp;
  int                last_served;
  int                we_lo, oe_lo, ce_lo;
  int                serve_log [$];

  // Monitor: samples on the falling edge, rst_n only ever changes just after a falling edge.
  always @(negedge sysclk) begin
    if (!rst_n) begin
      check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
      check("rst_dq_drive", dut.dq_oe, 0);
      check("rst_addr", sram_addr, 0);
      check("rst_ack", {fpga_ack, cpu_ack}, 0);
      check("rst_grant_busy", {grant, busy}, 0);
      check("rst_rdata", {fpga_rdata, cpu_rdata}, 0);
      n           = 0;
      last_served = 1;
      exp_rd[0]   = '0;
      exp_rd[1]   = '0;
    end else begin
      check("grant_legal", grant == 2'b11, 0);
      check("ack_onehot", cpu_ack & fpga_ack, 0);
      check("no_contention", !sram_oe_n && dut.dq_oe, 0);

      if (n == 0 && grant != 2'b00) begin
        gp = int'(grant[1]);
        check("grant_pending", pend_snap[gp], 1);
        if (pend_snap == 2'b11) check("grant_rr", gp, 1 - last_served);
        n     = 1;
        we_lo = 0;
        oe_lo = 0;
        ce_lo = 0;
      end

      if (n == 0) begin
        check("idle_busy", busy, 0);
        check("idle_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("idle_dq_drive", dut.dq_oe, 0);
        check("idle_ack", {fpga_ack, cpu_ack}, 0);
      end else begin
        check("txn_busy", busy, 1);
        check("txn_grant", grant, (gp == 0) ? 32'd1 : 32'd2);
        check("txn_dq_drive", dut.dq_oe, cur_we[gp]);
        if (n <= AC + 1 || cur_we[gp]) check("txn_addr", sram_addr, cur_addr[gp]);
        if (cur_we[gp]) check("txn_wdata", sram_dq, cur_wdata[gp]);
        we_lo += int'(!sram_we_n);
        oe_lo += int'(!sram_oe_n);
        ce_lo += int'(!sram_ce_n);
        if (n < DONE_N) begin
          check("early_ack", {fpga_ack, cpu_ack}, 0);
          n++;
        end else begin
          check("ack", {fpga_ack, cpu_ack}, (gp == 0) ? 32'd1 : 32'd2);
          check("done_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
          check("we_cycles", we_lo, cur_we[gp] ? AC : 0);
          check("oe_cycles", oe_lo, cur_we[gp] ? 0 : AC + 1);
          check("ce_cycles", ce_lo, AC + 1);
          if (cur_we[gp]) ref_mem[int'(cur_addr[gp])] = cur_wdata[gp];
          else exp_rd[gp] = ref_read(cur_addr[gp]);
          pend[gp]    = 1'b0;
          last_served = gp;
          serve_log.push_back(gp);
          n = 0;
        end
      end
      check("rdata_regs", {fpga_rdata, cpu_rdata}, {exp_rd[1], exp_rd[0]});
    end
    pend_snap = pend;
  end

  // One request from port p; call just after a rising edge. Inputs are scrambled once
  // granted, so only the values latched on the grant edge may be used.
  task automatic issue(input int p, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input bit late);
    int t;
    we_in[p]     = w;
    addr_in[p]   = a;
    wdata_in[p]  = d;
    cur_we[p]    = w;
    cur_addr[p]  = a;
    cur_wdata[p] = d;
    req[p]       = 1'b1;
    pend[p]      = 1'b1;
    t = 0;
    while (pend[p] && t < 64) begin
      @(posedge sysclk); #1;
      t++;
      if (grant == ((p == 0) ? 2'b01 : 2'b10)) begin
        we_in[p]    = 1'($urandom);
        addr_in[p]  = ADDR_W'($urandom);
        wdata_in[p] = DATA_W'($urandom);
      end
    end
    check("served_in_time", pend[p], 0);
    pend[p] = 1'b0;
    if (late) begin
      @(posedge sysclk); #1;
    end
    req[p] = 1'b0;
  endtask

  task automatic requester(input int p, input int count);
    for (int k = 0; k < count; k++) begin
      repeat ($urandom_range(1, 4)) @(posedge sysclk);
      #1;
      issue(p, 1'($urandom), ADDR_W'($urandom_range(0, 15) * 4099), DATA_W'($urandom),
            1'($urandom));
    end
  endtask

  task automatic do_reset();
    @(negedge sysclk); #1;
    rst_n = 1'b0;
    req   = '0;
    pend  = '0;
    repeat (2) @(negedge sysclk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int t;
    int code;
    req         = '0;
    we_in       = '0;
    addr_in[0]  = '0;
    addr_in[1]  = '0;
    wdata_in[0] = '0;
    wdata_in[1] = '0;
    pend        = '0;
    pend_snap   = '0;
    n           = 0;
    last_served = 1;
    exp_rd[0]   = '0;
    exp_rd[1]   = '0;
    repeat (2) @(negedge sysclk);
    #1 rst_n = 1'b1;

    // CPU write, then read it back
    @(posedge sysclk); #1;
    issue(0, 1'b1, 17'h1A5F0, 8'hC3, 1'b0);
    repeat (2) @(posedge sysclk); #1;
    issue(0, 1'b0, 17'h1A5F0, 8'h00, 1'b0);
    check("t1_readback", cpu_rdata, 8'hC3);

    // FPGA read of an unwritten location; CPU read data must stay put
    repeat (2) @(posedge sysclk); #1;
    issue(1, 1'b0, 17'h00010, 8'h00, 1'b0);
    check("t2_fpga_rdata", fpga_rdata, 8'h5A);
    check("t2_cpu_rdata", cpu_rdata, 8'hC3);

    // Both requesting from reset: CPU, FPGA, CPU, FPGA
    do_reset();
    serve_log.delete();
    @(posedge sysclk); #1;
    for (int r = 0; r < 2; r++) begin
      fork
        issue(0, 1'b1, 17'h00100, 8'h11, 1'b0);
        issue(1, 1'b0, 17'h00100, 8'h00, 1'b0);
      join
    end
    code = 0;
    for (int i = 0; i < serve_log.size() && i < 4; i++) code = code * 2 + serve_log[i];
    check("t3_count", serve_log.size(), 4);
    check("t3_order", code, 4'b0101);

    // CPU req dropped one cycle late must not be served twice
    repeat (2) @(posedge sysclk); #1;
    issue(0, 1'b0, 17'h00100, 8'h00, 1'b1);
    repeat (4) @(posedge sysclk); #1;
    check("t4_busy", busy, 0);
    check("t4_grant", grant, 0);

    // Reset during the ACCESS phase of a write
    @(posedge sysclk); #1;
    we_in[0]     = 1'b1;
    addr_in[0]   = 17'h0ABCD;
    wdata_in[0]  = 8'h77;
    cur_we[0]    = 1'b1;
    cur_addr[0]  = 17'h0ABCD;
    cur_wdata[0] = 8'h77;
    req[0]       = 1'b1;
    pend[0]      = 1'b1;
    t = 0;
    while (grant != 2'b01 && t < 20) begin
      @(posedge sysclk); #1;
      t++;
    end
    check("t5_granted", grant, 2'b01);
    @(posedge sysclk); #1;
    check("t5_in_access", {sram_ce_n, sram_we_n}, 2'b00);
    @(negedge sysclk); #1;
    rst_n   = 1'b0;
    req[0]  = 1'b0;
    pend[0] = 1'b0;
    @(negedge sysclk); #1;
    check("t5_abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    check("t5_abort_dq", dut.dq_oe, 0);
    check("t5_abort_ack", {fpga_ack, cpu_ack}, 0);
    check("t5_abort_idle", {grant, busy}, 0);
    @(negedge sysclk); #1;
    rst_n = 1'b1;
    @(posedge sysclk); #1;
    issue(0, 1'b1, 17'h0ABCD, 8'h3C, 1'b0);
    issue(0, 1'b0, 17'h0ABCD, 8'h00, 1'b0);
    check("t5_readback", cpu_rdata, 8'h3C);

    // Random traffic from both requesters
    fork
      requester(0, 40);
      requester(1, 40);
    join
    repeat (6) @(posedge sysclk);
    check("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
